alu_muldiv_seq: RTL and testbench

Multi-cycle sequencer that adds 32-bit unsigned multiply and divide to the core by driving the shared 32-bit ALU iteratively: one ALU add or subtract per cycle, with the shift/accumulate registers held locally. It sits beside the ALU, owns the ALU operand/opcode inputs while busy, and exposes a valid/ready request/response interface to the issue logic. The ALU itself is external; this block only drives it and consumes its result.

---
 rtl/alu_muldiv_seq.sv | 176 +++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: 32-bit unsigned MUL/MULHU/DIVU/REMU sequencer.
// It produces one result bit per cycle by driving the shared external ALU
// (one add or subtract per cycle) and keeps the shift/accumulate state locally.
module alu_muldiv_seq #(
    parameter bit DIVZ_FAST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        busy,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_cout
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [1:0]      op_q, op_n;
    logic [CW-1:0]   cnt, cnt_n;
    // acc: hi (multiply) / rem (divide)
    // qr : lo (multiply) / quo (divide)
    // opnd: mcand (multiply) / dvsr (divide)
    logic [W-1:0]    acc, acc_n;
    logic [W-1:0]    qr, qr_n;
    logic [W-1:0]    opnd, opnd_n;
    logic            req_ready_n;
    logic            resp_valid_n;
    logic [W-1:0]    resp_data_n;
    logic            busy_n;

    logic [W-1:0]    shifted;
    logic            take;
    logic            is_div_q;
    logic            accept;
    logic            divz_req;

    assign is_div_q = op_q[1];
    assign shifted  = {acc[W-2:0], qr[W-1]};
    // A set rem[31] means the shifted remainder exceeds 32 bits, so it is
    // always at least the divisor even when the ALU reports a borrow.
    assign take     = acc[W-1] | alu_cout;
    assign accept   = req_valid & req_ready;
    assign divz_req = req_op[1] & (req_b == '0);

    // ALU drive: a function of registered state only, never of req_*.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_ADD;
        if (state == S_RUN) begin
            if (is_div_q) begin
                alu_a  = shifted;
                alu_b  = opnd;
                alu_op = ALU_SUB;
            end else begin
                alu_a  = acc;
                alu_b  = opnd;
                alu_op = ALU_ADD;
            end
        end
    end

    // Next-state, datapath update and registered-output next values.
    always_comb begin
        state_n      = state;
        op_n         = op_q;
        cnt_n        = cnt;
        acc_n        = acc;
        qr_n         = qr;
        opnd_n       = opnd;
        resp_valid_n = resp_valid;
        resp_data_n  = resp_data;

        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    op_n   = req_op;
                    cnt_n  = '0;
                    acc_n  = '0;
                    qr_n   = req_op[1] ? req_a : req_b;
                    opnd_n = req_op[1] ? req_b : req_a;
                    if (DIVZ_FAST && divz_req) begin
                        state_n      = S_DONE;
                        resp_valid_n = 1'b1;
                        resp_data_n  = req_op[0] ? req_a : '1;
                    end else begin
                        state_n = S_RUN;
                    end
                end
            end

            S_RUN: begin
                cnt_n = cnt + CW'(1);
                if (is_div_q) begin
                    acc_n = take ? alu_result : shifted;
                    qr_n  = {qr[W-2:0], take};
                end else if (qr[0]) begin
                    acc_n = {alu_cout, alu_result[W-1:1]};
                    qr_n  = {alu_result[0], qr[W-1:1]};
                end else begin
                    acc_n = {1'b0, acc[W-1:1]};
                    qr_n  = {acc[0], qr[W-1:1]};
                end
                if (cnt == CW'(W - 1)) begin
                    state_n      = S_DONE;
                    resp_valid_n = 1'b1;
                    // op[0] selects the high/remainder half in both families.
                    resp_data_n  = op_q[0] ? acc_n : qr_n;
                end
            end

            S_DONE: begin
                if (resp_ready) begin
                    state_n      = S_IDLE;
                    resp_valid_n = 1'b0;
                end
            end

            default: begin
                state_n      = S_IDLE;
                resp_valid_n = 1'b0;
            end
        endcase

        req_ready_n = (state_n == S_IDLE);
        busy_n      = (state_n != S_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= '0;
            cnt        <= '0;
            acc        <= '0;
            qr         <= '0;
            opnd       <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            op_q       <= op_n;
            cnt        <= cnt_n;
            acc        <= acc_n;
            qr         <= qr_n;
            opnd       <= opnd_n;
            req_ready  <= req_ready_n;
            resp_valid <= resp_valid_n;
            resp_data  <= resp_data_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: two instances (DIVZ_FAST = 1 and 0), each with a
// behavioural ALU, checked every cycle against an arithmetic reference model.
module tb_alu_muldiv_seq;

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;
    localparam logic [1:0] MUL = 2'd0, MULHU = 2'd1, DIVU = 2'd2, REMU = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [1:0]  req_op     [2];
    logic [31:0] req_a      [2];
    logic [31:0] req_b      [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_data  [2];
    logic        busy       [2];
    logic [31:0] alu_a      [2];
    logic [31:0] alu_b      [2];
    logic [3:0]  alu_op     [2];
    logic [32:0] alu_sum    [2];

    int  total  = 0;
    int  passed = 0;
    bit  chk_en = 1'b0;

    // Reference model state (instance 0 has DIVZ_FAST = 1)
    int          n = 0;
    bit          m_pend [2];
    int          m_due  [2];
    logic [31:0] m_exp  [2];
    logic [31:0] m_last [2];
    logic [1:0]  m_op   [2];

    // External ALU: {carry, sum}; for SUB the carry is "no borrow" (a >= b).
    function automatic logic [32:0] alu_calc(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        if (op == SUB) return {1'b0, a} + {1'b0, ~b} + 33'd1;
        return {1'b0, a} + {1'b0, b};
    endfunction

    assign alu_sum[0] = alu_calc(alu_op[0], alu_a[0], alu_b[0]);
    assign alu_sum[1] = alu_calc(alu_op[1], alu_a[1], alu_b[1]);

    alu_muldiv_seq #(.DIVZ_FAST(1'b1)) dut_fast (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
        .req_a(req_a[0]), .req_b(req_b[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_data(resp_data[0]),
        .busy(busy[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]),
        .alu_result(alu_sum[0][31:0]), .alu_cout(alu_sum[0][32])
    );

    alu_muldiv_seq #(.DIVZ_FAST(1'b0)) dut_slow (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
        .req_a(req_a[1]), .req_b(req_b[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_data(resp_data[1]),
        .busy(busy[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]),
        .alu_result(alu_sum[1][31:0]), .alu_cout(alu_sum[1][32])
    );

    function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            MUL:     return p[31:0];
            MULHU:   return p[63:32];
            DIVU:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s inst%0d at edge %0d: got %h expected %h", name, k, n, act, exp);
    endtask

    // Model: edges are numbered; results become visible after the accept edge
    // plus 32 iterations, or right after the accept edge for a fast divide-by-zero.
    always @(posedge clk) begin
        int e;
        e = n + 1;
        n <= e;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pend[k] <= 1'b0;
                m_last[k] <= 32'd0;
            end else if (!m_pend[k]) begin
                if (req_valid[k]) begin
                    m_pend[k] <= 1'b1;
                    m_op[k]   <= req_op[k];
                    m_exp[k]  <= model_result(req_op[k], req_a[k], req_b[k]);
                    m_due[k]  <= (k == 0 && req_op[k][1] && req_b[k] == 32'd0) ? e : e + 32;
                end
            end else if (e > m_due[k] && resp_ready[k]) begin
                m_pend[k] <= 1'b0;
                m_last[k] <= m_exp[k];
            end
        end
    end

    // Per-cycle compare of all observable outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                if (m_pend[k]) begin
                    chk("busy", k, 32'(busy[k]), 32'd1);
                    chk("req_ready_busy", k, 32'(req_ready[k]), 32'd0);
                    chk("resp_valid", k, 32'(resp_valid[k]), 32'(n >= m_due[k]));
                    if (n >= m_due[k]) chk("resp_data", k, resp_data[k], m_exp[k]);
                    else chk("alu_op_run", k, 32'(alu_op[k]), 32'(m_op[k][1] ? SUB : ADD));
                end else begin
                    chk("idle_busy", k, 32'(busy[k]), 32'd0);
                    chk("idle_ready", k, 32'(req_ready[k]), 32'd1);
                    chk("idle_valid", k, 32'(resp_valid[k]), 32'd0);
                    chk("idle_data", k, resp_data[k], m_last[k]);
                    chk("idle_alu_op", k, 32'(alu_op[k]), 32'(ADD));
                    chk("idle_alu_ab", k, alu_a[k] | alu_b[k], 32'd0);
                end
            end
        end
    end

    // Present a request and hold it until accepted; t0 is the accept edge.
    task automatic issue(input int k, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int t0);
        int w;
        req_op[k] = op; req_a[k] = a; req_b[k] = b; req_valid[k] = 1'b1;
        w = 0;
        while (w < 200) begin
            @(negedge clk);
            if (req_ready[k]) break;
            w++;
        end
        if (w >= 200) chk("accept_timeout", k, 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        t0 = n;
    endtask

    // Directed op with literal expected data and response cycle (accept = cycle 0).
    task automatic run_op(input int k, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_cyc);
        int t0, w;
        resp_ready[k] = 1'b1;
        issue(k, op, a, b, t0);
        w = 0;
        while (w < 100 && !resp_valid[k]) begin
            @(negedge clk);
            w++;
        end
        if (!resp_valid[k]) chk("resp_timeout", k, 32'd0, 32'd1);
        chk("dir_data", k, resp_data[k], exp);
        chk("dir_cycle", k, 32'(n - t0 + 1), 32'(exp_cyc));
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'($urandom_range(1, 15));
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000 | 32'($urandom);
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int t0, w, k;
        logic [1:0]  op;
        logic [31:0] a, b;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_op[i] = 2'd0; req_a[i] = 32'd0; req_b[i] = 32'd0;
            resp_ready[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", i, 32'(req_ready[i]), 32'd1);
            chk("rst_valid", i, 32'(resp_valid[i]), 32'd0);
            chk("rst_data", i, resp_data[i], 32'd0);
            chk("rst_busy", i, 32'(busy[i]), 32'd0);
            chk("rst_alu_op", i, 32'(alu_op[i]), 32'(ADD));
        end
        chk_en = 1'b1;

        // Directed results
        run_op(0, MUL,   32'd7, 32'd6, 32'd42, 33);
        run_op(0, MULHU, 32'd7, 32'd6, 32'd0, 33);
        run_op(1, MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        run_op(1, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op(0, DIVU,  32'd100, 32'd7, 32'd14, 33);
        run_op(0, REMU,  32'd100, 32'd7, 32'd2, 33);
        run_op(1, DIVU,  32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33);
        run_op(1, REMU,  32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33);
        run_op(0, DIVU,  32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op(0, REMU,  32'd5, 32'd0, 32'd5, 1);
        run_op(1, DIVU,  32'd5, 32'd0, 32'hFFFF_FFFF, 33);
        run_op(1, REMU,  32'd5, 32'd0, 32'd5, 33);

        // Backpressure in DONE with a competing request held
        resp_ready[1] = 1'b0;
        issue(1, MUL, 32'd123, 32'd456, t0);
        w = 0;
        while (w < 100 && !resp_valid[1]) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk); #1;
        req_op[1] = DIVU; req_a[1] = 32'd9; req_b[1] = 32'd3; req_valid[1] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_data", 1, resp_data[1], 32'd56088);
            chk("bp_valid", 1, 32'(resp_valid[1]), 32'd1);
            chk("bp_ready", 1, 32'(req_ready[1]), 32'd0);
        end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        resp_ready[1] = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_ready", 1, 32'(req_ready[1]), 32'd1);
        chk("bp_idle_busy", 1, 32'(busy[1]), 32'd0);
        chk("bp_keep_data", 1, resp_data[1], 32'd56088);

        // Reset during RUN iteration 10
        issue(0, MUL, 32'd9, 32'd9, t0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_ready", 0, 32'(req_ready[0]), 32'd1);
        chk("mid_rst_valid", 0, 32'(resp_valid[0]), 32'd0);
        chk("mid_rst_busy", 0, 32'(busy[0]), 32'd0);
        chk("mid_rst_alu_op", 0, 32'(alu_op[0]), 32'(ADD));
        run_op(0, MUL, 32'd3, 32'd5, 32'd15, 33);

        // Randomized operations with random response backpressure
        for (int i = 0; i < 150; i++) begin
            k  = int'($urandom_range(0, 1));
            op = 2'($urandom);
            a  = rand_operand();
            b  = rand_operand();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            issue(k, op, a, b, t0);
            w = 0;
            while (w < 300 && m_pend[k]) begin
                resp_ready[k] = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                w++;
            end
            if (m_pend[k]) chk("rand_timeout", k, 32'd0, 32'd1);
            resp_ready[k] = 1'b1;
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
